// File: rtl/regex_pkg.sv
// regex_pkg
//   Types and defaults shared between the character front end (char_stream)
//   and the downstream pattern matcher.
//   CHAR_W        : width of one character
//   char_t        : one character
//   stream_ent_t  : one buffered entry {last, char}
//   DEF_DEPTH     : default character FIFO depth
//   DEF_IDX_W     : default width of the in-stream character index
package regex_pkg;

  localparam int CHAR_W    = 8;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_IDX_W = 16;

  typedef logic [CHAR_W-1:0] char_t;

  typedef struct packed {
    logic  last;
    char_t ch;
  } stream_ent_t;

  localparam int ENT_W = $bits(stream_ent_t);

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Generic single-clock FIFO. DEPTH must be a power of two (>= 2) so the
//   pointers wrap by natural binary overflow.
//   i_clk     : rising-edge clock
//   i_rst     : asynchronous active-high reset (pointers and count only)
//   i_clr     : synchronous clear; wins over push and pop
//   i_push    : write i_wdata (ignored when full)
//   i_pop     : discard the head entry (ignored when empty)
//   i_wdata   : write data
//   o_rdata   : head entry (undefined content when empty)
//   o_full    : count == DEPTH
//   o_empty   : count == 0
//   o_count   : current occupancy
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // Fullness is judged on the registered count, so a full FIFO refuses a
  // push even in a cycle where a pop also happens.
  assign w_push = i_push && !o_full  && !i_clr;
  assign w_pop  = i_pop  && !o_empty && !i_clr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never reset; stale entries are unreachable once the count
  // says they are gone.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/char_stream.sv
// char_stream
//   Byte-stream front end for the pattern matcher. Buffers host characters
//   in a small FIFO and presents them one per cycle with a running
//   in-stream index and an end-of-stream marker.
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset
//   flush      : synchronous clear of FIFO, index and overflow
//   inChar     : host character
//   inLast     : inChar ends its stream
//   inValid    : host offers inChar/inLast
//   inReady    : a character can be accepted this cycle
//   nextChar   : character presented to the matcher (0 when none)
//   charLast   : nextChar ends its stream
//   charValid  : nextChar is valid
//   charTake   : matcher consumes nextChar this cycle
//   charIndex  : zero-based position of nextChar in its stream
//   overflow   : sticky, host offered a character while inReady was low
module char_stream
  import regex_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [CHAR_W-1:0] inChar,
  input  logic             inLast,
  input  logic             inValid,
  output logic             inReady,
  output logic [CHAR_W-1:0] nextChar,
  output logic             charLast,
  output logic             charValid,
  input  logic             charTake,
  output logic [IDX_W-1:0] charIndex,
  output logic             overflow
);

  localparam int CW = $clog2(DEPTH + 1);

  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_push;
  logic          w_pop;
  stream_ent_t   w_wr_ent;
  logic [ENT_W-1:0] w_rd_bits;
  stream_ent_t   w_rd_ent;

  logic [IDX_W-1:0] r_char_index;
  logic             r_overflow;

  assign inReady   = (w_count != CW'(DEPTH));
  assign charValid = (w_count != '0);

  // Handshake qualification; flush is handled inside the FIFO so it
  // dominates both directions.
  assign w_push = inValid  && !w_full;
  assign w_pop  = charTake && !w_empty;

  assign w_wr_ent.last = inLast;
  assign w_wr_ent.ch   = inChar;

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_clr   (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wr_ent),
    .o_rdata (w_rd_bits),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_rd_ent = stream_ent_t'(w_rd_bits);

  // Gate the head entry when empty: the memory is never cleared, so an
  // empty FIFO would otherwise show stale data.
  assign nextChar  = charValid ? w_rd_ent.ch   : '0;
  assign charLast  = charValid ? w_rd_ent.last : 1'b0;
  assign charIndex = r_char_index;
  assign overflow  = r_overflow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_char_index <= '0;
      r_overflow   <= 1'b0;
    end else if (flush) begin
      r_char_index <= '0;
      r_overflow   <= 1'b0;
    end else begin
      // Index restarts after the last character of a stream; otherwise
      // it wraps freely.
      if (charValid && charTake) begin
        if (charLast) r_char_index <= '0;
        else          r_char_index <= r_char_index + IDX_W'(1);
      end
      if (inValid && !inReady) r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_char_stream.sv
module tb_char_stream;
  import regex_pkg::*;

  localparam int DEPTH = 8;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic [7:0]       inChar;
  logic             inLast;
  logic             inValid;
  logic             inReady;
  logic [7:0]       nextChar;
  logic             charLast;
  logic             charValid;
  logic             charTake;
  logic [IDX_W-1:0] charIndex;
  logic             overflow;

  int errors = 0;
  int checks = 0;

  // reference model: queue of {last, char}, stream index, sticky overflow
  logic [8:0]       m_q [$];
  logic [IDX_W-1:0] m_idx;
  logic             m_ovf;

  char_stream #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .inChar    (inChar),
    .inLast    (inLast),
    .inValid   (inValid),
    .inReady   (inReady),
    .nextChar  (nextChar),
    .charLast  (charLast),
    .charValid (charValid),
    .charTake  (charTake),
    .charIndex (charIndex),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic       vld;
    logic [8:0] head;
    vld  = (m_q.size() != 0);
    head = vld ? m_q[0] : 9'h000;
    check_val("charValid", 32'(charValid), 32'(vld));
    check_val("inReady",   32'(inReady),   32'(m_q.size() < DEPTH));
    check_val("nextChar",  32'(nextChar),  32'(head[7:0]));
    check_val("charLast",  32'(charLast),  32'(head[8]));
    check_val("charIndex", 32'(charIndex), 32'(m_idx));
    check_val("overflow",  32'(overflow),  32'(m_ovf));
  endtask

  // Called at a falling edge: check, drive, advance model, wait one cycle.
  task automatic step(input logic v, input logic [7:0] c, input logic l,
                      input logic t, input logic f);
    logic       rdy;
    logic       vld;
    logic [8:0] e;
    check_outputs();
    inValid  = v;
    inChar   = c;
    inLast   = l;
    charTake = t;
    flush    = f;
    if (f) begin
      m_q.delete();
      m_idx = '0;
      m_ovf = 1'b0;
    end else begin
      rdy = (m_q.size() < DEPTH);
      vld = (m_q.size() != 0);
      if (v && !rdy) m_ovf = 1'b1;
      if (vld && t) begin
        e = m_q.pop_front();
        if (e[8]) m_idx = '0;
        else      m_idx = m_idx + 1'b1;
      end
      if (v && rdy) m_q.push_back({l, c});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic t);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, t, 1'b0);
  endtask

  initial begin
    logic [7:0] word [4];
    reset    = 1'b1;
    flush    = 1'b0;
    inChar   = 8'h00;
    inLast   = 1'b0;
    inValid  = 1'b0;
    charTake = 1'b0;
    m_idx    = '0;
    m_ovf    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset state
    check_val("rst_inReady",   32'(inReady),   32'd1);
    check_val("rst_charValid", 32'(charValid), 32'd0);
    idle(1, 1'b0);

    // "test" with charTake held high
    word[0] = 8'h74; word[1] = 8'h65; word[2] = 8'h73; word[3] = 8'h74;
    for (int i = 0; i < 4; i++) step(1'b1, word[i], i == 3, 1'b1, 1'b0);
    idle(2, 1'b1);
    check_val("test_idx_back0", 32'(charIndex), 32'd0);

    // fill 8, refused 9th sets overflow, drain in order
    for (int i = 0; i < 8; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    check_val("fill_overflow", 32'(overflow), 32'd1);
    idle(10, 1'b1);

    // full FIFO with simultaneous push and pop: pop only
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'h50 + 8'(i), i == 7, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0);
    check_val("fullpp_ready", 32'(inReady), 32'd1);
    idle(9, 1'b1);

    // 20-character stream, push and pop every cycle (index wraps at 16)
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 8'h61 + 8'(i), i == 19, 1'b1, 1'b0);
    idle(3, 1'b1);

    // flush with push and pop in the same cycle
    for (int i = 0; i < 3; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hCC, 1'b0, 1'b1, 1'b1);
    check_val("flush_valid", 32'(charValid), 32'd0);
    idle(2, 1'b1);

    // asynchronous reset between edges with 5 buffered
    for (int i = 0; i < 5; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
    check_outputs();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    inValid  = 1'b0;
    charTake = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_charValid", 32'(charValid), 32'd0);
    check_val("arst_inReady",   32'(inReady),   32'd1);
    check_val("arst_index",     32'(charIndex), 32'd0);
    m_q.delete();
    m_idx = '0;
    m_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 8'h41, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);

    // randomized traffic with varying consumer pace
    for (int i = 0; i < 600; i++) begin
      int take_pct;
      take_pct = ((i / 100) % 2 == 0) ? 85 : 30;
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 6) == 0,
           ($urandom % 100) < take_pct, ($urandom % 60) == 0);
    end
    idle(12, 1'b1);
    check_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/char_stream.md
# char_stream

Byte-stream front end that sits directly upstream of the pattern matcher. Accepts characters from the host side over a valid/ready handshake, buffers them in a small FIFO, and presents them one per cycle on `nextChar` with a qualifying valid, a running stream index and an end-of-stream marker. Decouples host burstiness from the matcher's one-character-per-clock consumption.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2
- `IDX_W`, 16, width of the stream index counter
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `flush`  in  1  synchronous clear of FIFO contents and stream index
- `inChar`  in  8  host character
- `inLast`  in  1  marks `inChar` as the final character of a stream
- `inValid`  in  1  host offers `inChar`/`inLast`
- `inReady`  out  1  block can accept a character this cycle
- `nextChar`  out  8  character presented to the matcher
- `charLast`  out  1  `nextChar` is the last character of its stream
- `charValid`  out  1  `nextChar` is valid
- `charTake`  in  1  matcher consumes `nextChar` this cycle
- `charIndex`  out  `IDX_W`  zero-based position of `nextChar` within its stream
- `overflow`  out  1  sticky; set when `inValid` is high while `inReady` is low and `flush` is low

## Operation
- Storage: `DEPTH` × 9-bit entries {`inLast`, `inChar`}; write pointer, read pointer, occupancy count of width `$clog2(DEPTH+1)`.
- Push: `inValid && inReady` writes at the write pointer and advances it (wraps at `DEPTH`).
- Pop: `charValid && charTake` advances the read pointer (wraps). `charTake` while `charValid` is low is ignored.
- `inReady = (count != DEPTH)`; it does not depend on same-cycle `charTake`, so a full FIFO refuses a push even when a pop occurs.
- `charValid = (count != 0)`; `nextChar`/`charLast` come from the entry at the read pointer.
- Simultaneous push and pop: count unchanged, both pointers advance.
- `charIndex`: increments by 1 on each pop; returns to 0 on a pop with `charLast` = 1; wraps modulo 2^`IDX_W` within a stream (no saturation).
- `overflow`: sticky, cleared only by `reset` or `flush`. A refused push is dropped, never written.
- `flush`: takes priority over push and pop in the same cycle; count, pointers and `charIndex` go to 0, `overflow` to 0. Memory contents are not cleared.
- No explicit FSM; state is count plus pointers. The effective states are EMPTY (count 0), PARTIAL and FULL (count `DEPTH`).

## Timing
- Reset values: `inReady` = 1, `charValid` = 0, `nextChar` = 0, `charLast` = 0, `charIndex` = 0, `overflow` = 0; count and pointers = 0.
- Reset asserted mid-stream discards all buffered data immediately and asynchronously.
- Latency: a character accepted at edge N is visible at `nextChar` with `charValid` = 1 after edge N, so it can be taken at edge N+1.
- Throughput: one push and one pop per cycle sustained. A FIFO at `DEPTH`−1 with push and pop every cycle never blocks.
- `nextChar`, `charLast` and `charValid` are read-side combinational from registers only. There is no combinational path from `inValid` or `charTake` to any output except through a clock edge.
- `nextChar` holds stable while `charValid` = 1 and `charTake` = 0.

## Structure
- Shared package `regex_pkg`: `CHAR_W` = 8, `char_t` typedef, default `DEPTH`/`IDX_W` constants, which the matcher also uses.
- One natural sub-module: `sync_fifo`, a generic width/depth FIFO providing push/pop/full/empty/count. `char_stream` wraps it and adds the index counter, last handling, overflow and flush.

## Test plan
- Reset, then push "test" (0x74,0x65,0x73,0x74, last on the final 't') with `charTake` held high → `nextChar` sequence t,e,s,t on consecutive cycles, `charIndex` 0,1,2,3, `charLast` only on index 3, and `charIndex` back to 0 after that pop.
- Push 8 characters with `charTake` = 0 → `inReady` drops after the 8th; a 9th `inValid` sets `overflow`; then pop all 8 → the original order is preserved and the 9th character never appears.
- FIFO full plus simultaneous `inValid` and `charTake` → the pop occurs, the push is refused, count = 7, and `overflow` is set.
- Stream of 20 characters with `charTake` every cycle and `inValid` every cycle → the pointers wrap twice, there is no stall, and the data is in order.
- Push 3 characters, then assert `flush` together with `inValid` and `charTake` → the next cycle shows `charValid` = 0, `charIndex` = 0, `overflow` = 0, and nothing is written.
- Assert `reset` asynchronously between edges with 5 characters buffered → `charValid` = 0 and `inReady` = 1 before the next edge; after release, a new push is presented with `charIndex` = 0.
